// File: rtl/aes_enc_core_param.sv
// rtl/aes_enc_core_param.sv - iterative AES-128/192/256 encryption core, one round per clock
// Round keys are expanded on the fly from a sliding window of the last NK key-schedule words.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[a];
endmodule

module aes_enc_core_param #(
   parameter int KEY_BITS = 128
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [KEY_BITS-1:0] key,
   input  logic [127:0]        plain_txt,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        cypher_txt,
   output logic                busy
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_enc_core_param: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [127:0] blk;
   logic [3:0]   rnd;
   logic [31:0]  win [NK];
   logic [31:0]  ext [NK+4];
   logic [2:0]   n_mod;
   logic [3:0]   n_div;
   logic [3:0]   m4_raw;
   logic         m4_wrap;
   logic         accept;
   logic         last_rnd;
   logic [127:0] rk;
   logic [127:0] sb, sr, mc, rnd_out;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign accept   = in_valid & in_ready;
   assign last_rnd = (rnd == 4'(NR));

   // Window holds w[n-NK..n-1]; each round appends w[n..n+3] and slides by 4,
   // so rk[rnd] always sits at ext[4..7] whatever NK is.
   for (genvar j = 0; j < 4; j++) begin : g_kw
      logic [31:0] prev, sub_in, sub, temp, w;
      logic [3:0]  m_raw, m, idx;
      logic        wrap;

      if (j == 0) begin : g_first
         assign prev = win[NK-1];
      end else begin : g_chain
         assign prev = g_kw[j-1].w;
      end

      assign m_raw  = {1'b0, n_mod} + 4'(j);
      assign wrap   = (m_raw >= 4'(NK));
      assign m      = wrap ? m_raw - 4'(NK) : m_raw;
      assign idx    = n_div + {3'b000, wrap};
      assign sub_in = (m == 4'd0) ? {prev[23:0], prev[31:24]} : prev;

      for (genvar b = 0; b < 4; b++) begin : g_sb
         aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub[8*b +: 8])
         );
      end

      always_comb begin
         if (m == 4'd0)
            temp = sub ^ {rcon(idx), 24'h000000};
         else if (NK == 8 && m == 4'd4)
            temp = sub;
         else
            temp = prev;
      end

      assign w = win[j] ^ temp;
   end

   for (genvar k = 0; k < NK; k++) begin : g_ext_win
      assign ext[k] = win[k];
   end
   for (genvar j = 0; j < 4; j++) begin : g_ext_new
      assign ext[NK+j] = g_kw[j].w;
   end

   assign rk      = {ext[4], ext[5], ext[6], ext[7]};
   assign m4_raw  = {1'b0, n_mod} + 4'd4;
   assign m4_wrap = (m4_raw >= 4'(NK));

   for (genvar b = 0; b < 16; b++) begin : g_sub_bytes
      aes_sbox u_sbox (
         .a (blk[127-8*b -: 8]),
         .y (sb[127-8*b -: 8])
      );
   end

   // Byte 4c+r is row r of column c; row r rotates left by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   assign rnd_out = (last_rnd ? sr : mc) ^ rk;

   always_ff @(posedge CLK) begin
      if (rst)
         fsm <= IDLE;
      else
         fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (in_valid) fsm_nxt = ROUND;
         ROUND:   if (last_rnd) fsm_nxt = DONE;
         DONE:    if (out_ready) fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (fsm == IDLE);
      out_valid = (fsm == DONE);
      busy      = (fsm != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         rnd        <= 4'd0;
         cypher_txt <= 128'd0;
         n_mod      <= 3'd0;
         n_div      <= 4'd0;
      end else if (accept) begin
         blk   <= plain_txt ^ key[KEY_BITS-1 -: 128];
         rnd   <= 4'd1;
         n_mod <= 3'd0;
         n_div <= 4'd1;
         for (int k = 0; k < NK; k++)
            win[k] <= key[KEY_BITS-1-32*k -: 32];
      end else if (fsm == ROUND) begin
         blk   <= rnd_out;
         n_mod <= 3'(m4_wrap ? m4_raw - 4'(NK) : m4_raw);
         n_div <= n_div + {3'b000, m4_wrap};
         for (int k = 0; k < NK; k++)
            win[k] <= ext[k+4];
         if (last_rnd)
            cypher_txt <= rnd_out;
         else
            rnd <= rnd + 4'd1;
      end
   end
endmodule

// File: tb/tb_aes_enc_core_param.sv
// tb/tb_aes_enc_core_param.sv - directed FIPS-197 vectors on 128/192/256-bit instances
module tb_aes_enc_core_param;
   localparam logic [255:0] KSEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT1   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT1   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         CLK = 1'b0;
   logic         rst;
   logic [255:0] key_bus;
   logic [127:0] pt_bus;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic         busy      [3];
   logic [127:0] cypher    [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   aes_enc_core_param #(.KEY_BITS(128)) u_dut128 (
      .CLK(CLK), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .key(key_bus[255:128]), .plain_txt(pt_bus), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .cypher_txt(cypher[0]), .busy(busy[0])
   );
   aes_enc_core_param #(.KEY_BITS(192)) u_dut192 (
      .CLK(CLK), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .key(key_bus[255:64]), .plain_txt(pt_bus), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .cypher_txt(cypher[1]), .busy(busy[1])
   );
   aes_enc_core_param #(.KEY_BITS(256)) u_dut256 (
      .CLK(CLK), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .key(key_bus), .plain_txt(pt_bus), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .cypher_txt(cypher[2]), .busy(busy[2])
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_block(input int d, input logic [255:0] k, input logic [127:0] pt,
                            input logic [127:0] exp, input int lat, input string tag);
      int cnt;
      chk({tag, " in_ready"}, in_ready[d], 1'b1);
      key_bus     = k;
      pt_bus      = pt;
      in_valid[d] = 1'b1;
      step();
      in_valid[d] = 1'b0;
      chk({tag, " busy"}, busy[d], 1'b1);
      cnt = 0;
      while (!out_valid[d] && cnt < 40) begin
         step();
         cnt++;
      end
      chk({tag, " latency"}, cnt, lat);
      chk({tag, " cypher"}, cypher[d], exp);
      out_ready[d] = 1'b1;
      step();
      out_ready[d] = 1'b0;
      chk({tag, " drained"}, out_valid[d], 1'b0);
   endtask

   initial begin
      int cyc, nacc, nout;
      int acc_t [2];
      logic [127:0] outs [2];
      logic pend;

      rst     = 1'b1;
      key_bus = '0;
      pt_bus  = '0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end
      step();
      step();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst%0d out_valid", d), out_valid[d], 1'b0);
         chk($sformatf("rst%0d cypher", d), cypher[d], 128'd0);
         chk($sformatf("rst%0d busy", d), busy[d], 1'b0);
         chk($sformatf("rst%0d in_ready", d), in_ready[d], 1'b1);
      end
      rst = 1'b0;
      step();

      run_block(0, {K128, 128'd0}, PT1, CT1, 10, "aes128 fips");
      run_block(1, KSEQ, PT2, CT192, 12, "aes192");
      run_block(2, KSEQ, PT2, CT256, 14, "aes256");

      // backpressure with scrambled inputs and in_valid held during ROUND/DONE
      key_bus     = KSEQ;
      pt_bus      = PT2;
      in_valid[0] = 1'b1;
      step();
      for (int c = 0; c < 30; c++) begin
         key_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt_bus  = {$urandom, $urandom, $urandom, $urandom};
         chk("bp in_ready", in_ready[0], 1'b0);
         if (c >= 10) begin
            chk("bp out_valid", out_valid[0], 1'b1);
            chk("bp cypher", cypher[0], CT128);
         end
         step();
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      step();
      out_ready[0] = 1'b0;
      chk("bp released", out_valid[0], 1'b0);
      chk("bp idle", in_ready[0], 1'b1);

      // reset while round 5 is executing
      key_bus     = KSEQ;
      pt_bus      = PT2;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      for (int c = 0; c < 4; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst out_valid", out_valid[0], 1'b0);
      chk("midrst cypher", cypher[0], 128'd0);
      chk("midrst busy", busy[0], 1'b0);
      chk("midrst in_ready", in_ready[0], 1'b1);
      run_block(0, {K128, 128'd0}, PT1, CT1, 10, "after rst");

      // back-to-back with in_valid and out_ready held high
      key_bus      = {K128, 128'd0};
      pt_bus       = PT1;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      cyc  = 0;
      nacc = 0;
      nout = 0;
      pend = 1'b0;
      acc_t[0] = 0;
      acc_t[1] = 0;
      outs[0]  = '0;
      outs[1]  = '0;
      while (nout < 2 && cyc < 80) begin
         if (in_valid[0] && in_ready[0] && nacc < 2) begin
            acc_t[nacc] = cyc;
            nacc++;
            pend = 1'b1;
         end
         if (out_valid[0] && out_ready[0]) begin
            outs[nout] = cypher[0];
            nout++;
         end
         step();
         cyc++;
         if (pend) begin
            pend = 1'b0;
            if (nacc == 1) begin
               key_bus = KSEQ;
               pt_bus  = PT2;
            end else begin
               in_valid[0] = 1'b0;
            end
         end
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      chk("b2b accepts", nacc, 2);
      chk("b2b outputs", nout, 2);
      chk("b2b spacing", acc_t[1] - acc_t[0], 12);
      chk("b2b first", outs[0], CT1);
      chk("b2b second", outs[1], CT128);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
